sdram_bus_arbiter: RTL and testbench
====================================

Name: sdram_bus_arbiter

Overview:
- Multi-port round-robin arbiter placed in front of the chip-level SDRAM controller's system bus.
- Shares the controller's single request/response interface among NUM_PORTS requesters, e.g. CPU, video DMA and audio.
- Holds the grant for the full length of a write burst.
- Routes in-order read response beats back to the originating port through a response-tag FIFO.

Parameters:
- NUM_PORTS, 2, number of requester ports (2..8).
- AW, 26, byte address width, matches controller.
- DW, 16, data width, matches controller.
- TAG_DEPTH, 4, outstanding read requests tracked (power of 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- p_req_read  in  NUM_PORTS  per-port read request.
- p_req_write  in  NUM_PORTS  per-port write request.
- p_req_addr  in  NUM_PORTS*AW  per-port address; port i occupies slice [i*AW +: AW].
- p_req_burst  in  NUM_PORTS  per-port burst flag.
- p_req_burst_len  in  NUM_PORTS*3  per-port burst length code.
- p_req_wdata  in  NUM_PORTS*DW  per-port write data.
- p_req_byteenable  in  NUM_PORTS*2  per-port byte enables.
- p_req_ready  out  NUM_PORTS  per-port accept.
- p_rsp_valid  out  NUM_PORTS  per-port read data valid.
- p_rsp_rdata  out  DW  read data, broadcast to all ports.
- bus_req_read / bus_req_write / bus_req_burst  out  1 each  to controller.
- bus_req_addr  out  AW  to controller.
- bus_req_burst_len  out  3  to controller.
- bus_req_wdata  out  DW  to controller.
- bus_req_byteenable  out  2  to controller.
- bus_req_ready  in  1  from controller.
- bus_rsp_valid  in  1  from controller.
- bus_rsp_rdata  in  DW  from controller.
- err_orphan_rsp  out  1  sticky: bus_rsp_valid received while tag FIFO empty.

Behaviour:
- Reset values:
  - state IDLE, rr_ptr=0, tag FIFO empty.
  - All p_req_ready, p_rsp_valid and bus_req_read/write are 0.
  - p_rsp_rdata, bus_req_addr, bus_req_wdata and other bus_req_* fields are 0.
  - err_orphan_rsp=0.
- Reset asserted mid-transfer aborts immediately to the reset state; in-flight tags are discarded.
- Beat count: beats = 1<<burst_len for codes 0..3; codes 4..7 mean 8 beats; burst=0 means 1 beat.
- Request eligibility: port i is eligible when p_req_read[i]|p_req_write[i].
  - A read is eligible only if the tag FIFO is not full.
  - If a port asserts both read and write, write wins.
- State IDLE:
  - If any port is eligible, register grant = first eligible port searching from rr_ptr upward with wrap, and latch op (read/write) and beat count.
  - Go to BUSY. This costs one arbitration bubble cycle.
- State BUSY:
  - bus_req_* = the granted port's fields, with only the latched op asserted.
  - p_req_ready[grant] = bus_req_ready; every other port sees ready=0.
  - Read: the first handshake pushes {grant, beats} into the tag FIFO, then the block returns to IDLE.
  - Write: each handshake decrements the beat counter. On the last beat, go to IDLE.
  - On leaving BUSY, rr_ptr = grant+1 mod NUM_PORTS.
- A granted port must hold its request asserted until its final handshake.
  - If it drops the request before the first handshake, the block returns to IDLE without updating rr_ptr.
  - Dropping mid-burst is a protocol violation; the block stays in BUSY.
- Response path:
  - p_rsp_valid[head.port] = bus_rsp_valid, combinational, zero latency.
  - p_rsp_rdata = bus_rsp_rdata.
  - Each valid beat decrements the head remaining count; when it reaches 0 the tag is popped.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- FIFO full: reads are blocked from arbitration; writes remain grantable.
- bus_rsp_valid with the FIFO empty: no p_rsp_valid is driven, and err_orphan_rsp sets and stays set until reset.
- Fairness: a continuously requesting port waits at most NUM_PORTS-1 transfers.

Test Plan:
- Port0 single read at 0x100 while idle -> bus_req_read rises 1 cycle later with addr 0x100; after the controller returns 1 beat 0xBEEF, p_rsp_valid[0]=1 with rdata 0xBEEF and the FIFO is empty.
- Ports 0 and 1 issue continuous single writes -> grants alternate 0,1,0,1; p_req_ready is never asserted to the non-granted port.
- Port1 write burst with burst_len=2, while port0 requests a read the whole time -> all 4 port1 beats complete back-to-back before port0 is granted.
- Port0 read with burst_len=3, then port1 read with burst_len=0 -> 8 valid beats go to port0, then 1 to port1; tag push and pop in the same cycle keep the count correct.
- Five reads are queued with TAG_DEPTH=4 and the controller withholds responses -> the 5th read is not granted, but a pending write from the other port is; after one response completes, the 5th read is granted.
- bus_rsp_valid pulses at idle -> err_orphan_rsp=1 and stays set; asserting rst_n low mid-burst clears all outputs asynchronously.

Source files
------------

// File: rtl/sdram_bus_arbiter.sv
// sdram_bus_arbiter
//   Round-robin arbiter sharing one SDRAM-controller request/response bus among
//   NUM_PORTS requesters. A grant is held for the whole of a write burst; a read
//   is one address handshake whose response beats are routed back in order via
//   a tag FIFO of {port, beats}.
// Ports
//   clk, rst_n              clock, async active-low reset
//   p_req_*                 per-port request fields (packed, port i at [i*W +: W])
//   p_req_ready             per-port accept (only the granted port sees ready)
//   p_rsp_valid/p_rsp_rdata read data routed to the owning port
//   bus_req_*/bus_rsp_*     controller side
//   err_orphan_rsp          sticky: response beat arrived with no tag outstanding
module sdram_bus_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int AW        = 26,
  parameter int DW        = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PORTS-1:0]    p_req_read,
  input  logic [NUM_PORTS-1:0]    p_req_write,
  input  logic [NUM_PORTS*AW-1:0] p_req_addr,
  input  logic [NUM_PORTS-1:0]    p_req_burst,
  input  logic [NUM_PORTS*3-1:0]  p_req_burst_len,
  input  logic [NUM_PORTS*DW-1:0] p_req_wdata,
  input  logic [NUM_PORTS*2-1:0]  p_req_byteenable,
  output logic [NUM_PORTS-1:0]    p_req_ready,
  output logic [NUM_PORTS-1:0]    p_rsp_valid,
  output logic [DW-1:0]           p_rsp_rdata,
  output logic                    bus_req_read,
  output logic                    bus_req_write,
  output logic                    bus_req_burst,
  output logic [AW-1:0]           bus_req_addr,
  output logic [2:0]              bus_req_burst_len,
  output logic [DW-1:0]           bus_req_wdata,
  output logic [1:0]              bus_req_byteenable,
  input  logic                    bus_req_ready,
  input  logic                    bus_rsp_valid,
  input  logic [DW-1:0]           bus_rsp_rdata,
  output logic                    err_orphan_rsp
);
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] TAG_FULL = (PW+1)'(TAG_DEPTH);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q;
  logic [GW-1:0]  grant_q, rr_q;
  logic           op_wr_q;
  logic [3:0]     beats_q;    // write: beats remaining; read: beats to tag
  logic           started_q;  // a handshake has happened under this grant
  logic [GW-1:0]  tag_port_q [TAG_DEPTH];
  logic [3:0]     tag_rem_q  [TAG_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    cnt_q;
  logic           err_q;

  function automatic logic [3:0] beats_f(input logic burst, input logic [2:0] len);
    if (!burst)      return 4'd1;
    else if (len[2]) return 4'd8;
    else             return 4'd1 << len[1:0];
  endfunction

  logic fifo_full, fifo_empty;
  assign fifo_full  = (cnt_q == TAG_FULL);
  assign fifo_empty = (cnt_q == '0);

  // Reads need a free tag slot; writes are always eligible.
  logic [NUM_PORTS-1:0] elig;
  assign elig = p_req_write | (p_req_read & {NUM_PORTS{~fifo_full}});

  // First eligible port from rr_q upward with wrap: scan high-to-low offset
  // so the lowest offset wins.
  logic          pick_vld;
  logic [GW-1:0] pick;
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_PORTS) idx -= NUM_PORTS;
      if (elig[idx]) begin
        pick_vld = 1'b1;
        pick     = GW'(idx);
      end
    end
  end

  logic busy, held, hs, push, rsp_hit, pop;
  logic [GW-1:0] head_port, rr_next;
  logic [3:0]    head_rem;

  assign busy = (state_q == BUSY);
  // The op is gated by the live request so a dropped request never handshakes.
  assign held = op_wr_q ? p_req_write[grant_q] : p_req_read[grant_q];
  assign bus_req_write      = busy &  op_wr_q & held;
  assign bus_req_read       = busy & ~op_wr_q & held;
  assign bus_req_addr       = busy ? p_req_addr[int'(grant_q)*AW +: AW] : '0;
  assign bus_req_burst      = busy & p_req_burst[grant_q];
  assign bus_req_burst_len  = busy ? p_req_burst_len[int'(grant_q)*3 +: 3] : '0;
  assign bus_req_wdata      = busy ? p_req_wdata[int'(grant_q)*DW +: DW] : '0;
  assign bus_req_byteenable = busy ? p_req_byteenable[int'(grant_q)*2 +: 2] : '0;
  assign hs      = (bus_req_read | bus_req_write) & bus_req_ready;
  assign push    = hs & ~op_wr_q;
  assign rr_next = (grant_q == GW'(NUM_PORTS-1)) ? '0 : grant_q + GW'(1);

  always_comb begin
    p_req_ready = '0;
    if (busy) p_req_ready[grant_q] = bus_req_ready;
  end

  assign head_port = tag_port_q[rd_ptr_q];
  assign head_rem  = tag_rem_q[rd_ptr_q];
  assign rsp_hit   = bus_rsp_valid & ~fifo_empty;
  assign pop       = rsp_hit & (head_rem == 4'd1);

  always_comb begin
    p_rsp_valid = '0;
    if (rsp_hit) p_rsp_valid[head_port] = 1'b1;
  end
  assign p_rsp_rdata    = rsp_hit ? bus_rsp_rdata : '0;
  assign err_orphan_rsp = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      op_wr_q   <= 1'b0;
      beats_q   <= '0;
      started_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_port_q[i] <= '0;
        tag_rem_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: if (pick_vld) begin
          grant_q   <= pick;
          op_wr_q   <= p_req_write[pick];
          beats_q   <= beats_f(p_req_burst[pick], p_req_burst_len[int'(pick)*3 +: 3]);
          started_q <= 1'b0;
          state_q   <= BUSY;
        end
        BUSY: begin
          if (hs) begin
            started_q <= 1'b1;
            if (!op_wr_q || beats_q == 4'd1) begin
              state_q <= IDLE;
              rr_q    <= rr_next;
            end else begin
              beats_q <= beats_q - 4'd1;
            end
          end else if (!held && !started_q) begin
            state_q <= IDLE;  // abandoned before any handshake: no rr advance
          end
        end
        default: state_q <= IDLE;
      endcase

      if (push) begin
        tag_port_q[wr_ptr_q] <= grant_q;
        tag_rem_q[wr_ptr_q]  <= beats_q;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (rsp_hit) begin
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        else     tag_rem_q[rd_ptr_q] <= head_rem - 4'd1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (bus_rsp_valid && fifo_empty) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_bus_arbiter.sv
module tb_sdram_bus_arbiter;
  localparam int N = 2, AW = 26, DW = 16, TD = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    p_req_read, p_req_write, p_req_burst, p_req_ready, p_rsp_valid;
  logic [N*AW-1:0] p_req_addr;
  logic [N*3-1:0]  p_req_burst_len;
  logic [N*DW-1:0] p_req_wdata;
  logic [N*2-1:0]  p_req_byteenable;
  logic [DW-1:0]   p_rsp_rdata, bus_req_wdata, bus_rsp_rdata;
  logic            bus_req_read, bus_req_write, bus_req_burst, bus_req_ready, bus_rsp_valid;
  logic [AW-1:0]   bus_req_addr;
  logic [2:0]      bus_req_burst_len;
  logic [1:0]      bus_req_byteenable;
  logic            err_orphan_rsp;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  sdram_bus_arbiter #(.NUM_PORTS(N), .AW(AW), .DW(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req_read(p_req_read), .p_req_write(p_req_write), .p_req_addr(p_req_addr),
    .p_req_burst(p_req_burst), .p_req_burst_len(p_req_burst_len),
    .p_req_wdata(p_req_wdata), .p_req_byteenable(p_req_byteenable),
    .p_req_ready(p_req_ready), .p_rsp_valid(p_rsp_valid), .p_rsp_rdata(p_rsp_rdata),
    .bus_req_read(bus_req_read), .bus_req_write(bus_req_write), .bus_req_burst(bus_req_burst),
    .bus_req_addr(bus_req_addr), .bus_req_burst_len(bus_req_burst_len),
    .bus_req_wdata(bus_req_wdata), .bus_req_byteenable(bus_req_byteenable),
    .bus_req_ready(bus_req_ready), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
    .err_orphan_rsp(err_orphan_rsp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    p_req_read = '0; p_req_write = '0; p_req_burst = '0; p_req_burst_len = '0;
    p_req_addr = {26'h0002000, 26'h0000100};
    p_req_wdata = {16'h2222, 16'h1111};
    p_req_byteenable = {2'b10, 2'b11};
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b0; bus_rsp_rdata = 16'h5A5A;

    // Reset state
    #12;
    chk("rst_ready", p_req_ready, 0);
    chk("rst_rspv", p_rsp_valid, 0);
    chk("rst_rdata", p_rsp_rdata, 0);
    chk("rst_rd_wr", {bus_req_read, bus_req_write}, 0);
    chk("rst_addr", bus_req_addr, 0);
    chk("rst_wdata", bus_req_wdata, 0);
    chk("rst_err", err_orphan_rsp, 0);
    bus_rsp_rdata = '0;
    #5 rst_n = 1'b1;
    tick();

    // 1: port0 single read at 0x100
    p_req_read[0] = 1'b1;
    #1 chk("t1_bubble", bus_req_read, 0);
    tick();
    chk("t1_rd", bus_req_read, 1);
    chk("t1_wr", bus_req_write, 0);
    chk("t1_addr", bus_req_addr, 32'h100);
    chk("t1_ready", p_req_ready, 2'b01);
    tick();
    p_req_read[0] = 1'b0;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 16'hBEEF;
    #1 chk("t1_rspv", p_rsp_valid, 2'b01);
    chk("t1_rdata", p_rsp_rdata, 16'hBEEF);
    tick();
    bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;

    // 2: continuous single writes from both ports; rr points at port1 now
    p_req_write = 2'b11;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("t2_ready", p_req_ready, (g % 2 == 0) ? 2'b10 : 2'b01);
      chk("t2_addr", bus_req_addr, (g % 2 == 0) ? 32'h2000 : 32'h100);
      chk("t2_wr", bus_req_write, 1);
      tick();
      chk("t2_gap", p_req_ready, 0);
    end
    p_req_write = '0;

    // 3: port1 4-beat write burst while port0 holds a read
    p_req_burst[1] = 1'b1; p_req_burst_len[5:3] = 3'd2;
    p_req_write[1] = 1'b1; p_req_read[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("t3_ready", p_req_ready, 2'b10);
      chk("t3_wr", bus_req_write, 1);
      chk("t3_blen", {bus_req_burst, bus_req_burst_len}, 4'b1010);
    end
    chk("t3_wdata", bus_req_wdata, 16'h2222);
    chk("t3_be", bus_req_byteenable, 2'b10);
    tick();
    p_req_write[1] = 1'b0;
    #1 chk("t3_idle", p_req_ready, 0);
    tick();
    chk("t3_rd", bus_req_read, 1);
    chk("t3_rdready", p_req_ready, 2'b01);
    tick();
    p_req_read[0] = 1'b0;
    p_req_burst[1] = 1'b0; p_req_burst_len[5:3] = 3'd0;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 16'h1234;
    #1 chk("t3_rspv", p_rsp_valid, 2'b01);
    tick();
    bus_rsp_valid = 1'b0;

    // 4: port0 8-beat read, then port1 single; push/pop coincide on beat 7
    p_req_read[0] = 1'b1; p_req_burst[0] = 1'b1; p_req_burst_len[2:0] = 3'd3;
    tick();
    chk("t4_blen", bus_req_burst_len, 3);
    tick();
    p_req_read[0] = 1'b0; p_req_burst[0] = 1'b0; p_req_burst_len[2:0] = 3'd0;
    p_req_burst[1] = 1'b1;
    for (int b = 0; b < 9; b++) begin
      if (b == 6) p_req_read[1] = 1'b1;
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 16'h1000 + 16'(b);
      #1 chk("t4_rspv", p_rsp_valid, (b < 8) ? 2'b01 : 2'b10);
      chk("t4_rdata", p_rsp_rdata, 32'h1000 + b);
      if (b == 7) begin
        chk("t4_p1rd", bus_req_read, 1);
        chk("t4_p1ready", p_req_ready, 2'b10);
      end
      tick();
      if (b == 7) p_req_read[1] = 1'b0;
    end
    bus_rsp_valid = 1'b0;
    p_req_burst[1] = 1'b0;

    // 5: fill tag FIFO with 4 reads, 5th blocked; write from port1 still granted
    p_req_read[0] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("t5_rd", bus_req_read, 1);
      tick();
    end
    tick();
    chk("t5_blocked", {bus_req_read, p_req_ready}, 0);
    p_req_write[1] = 1'b1;
    tick();
    chk("t5_wr", bus_req_write, 1);
    chk("t5_wready", p_req_ready, 2'b10);
    tick();
    p_req_write[1] = 1'b0;
    tick();
    chk("t5_blocked2", bus_req_read, 0);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 16'h5555;
    #1 chk("t5_rspv", p_rsp_valid, 2'b01);
    tick();
    bus_rsp_valid = 1'b0;
    #1 chk("t5_blocked3", bus_req_read, 0);
    tick();
    chk("t5_5th", bus_req_read, 1);
    chk("t5_5thready", p_req_ready, 2'b01);
    tick();
    p_req_read[0] = 1'b0;
    for (int d = 0; d < 4; d++) begin
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 16'h6000 + 16'(d);
      #1 chk("t5_drain", p_rsp_valid, 2'b01);
      tick();
    end
    bus_rsp_valid = 1'b0;

    // 6: orphan response, then async reset mid-burst
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 16'hDEAD;
    #1 chk("t6_norsp", p_rsp_valid, 0);
    chk("t6_err0", err_orphan_rsp, 0);
    tick();
    bus_rsp_valid = 1'b0;
    chk("t6_err1", err_orphan_rsp, 1);
    tick(); tick();
    chk("t6_sticky", err_orphan_rsp, 1);
    p_req_write[1] = 1'b1; p_req_burst[1] = 1'b1; p_req_burst_len[5:3] = 3'd3;
    tick();
    chk("t6_busy", bus_req_write, 1);
    tick();
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_wr", bus_req_write, 0);
    chk("t6_rst_ready", p_req_ready, 0);
    chk("t6_rst_addr", bus_req_addr, 0);
    chk("t6_rst_blen", bus_req_burst_len, 0);
    chk("t6_rst_err", err_orphan_rsp, 0);
    p_req_write = '0; p_req_burst = '0; p_req_burst_len = '0;
    tick();
    rst_n = 1'b1;
    p_req_write = 2'b11;
    tick();
    chk("t6_rr0", p_req_ready, 2'b01);
    tick();
    p_req_write = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
